fp32_stream_accumulator: RTL
============================

// Module: fp32_stream_accumulator
// PURPOSE
// - Streaming FP32 sum-reduction controller that wraps the combinational FP32 adder in a feedback loop.
// - Upstream: a valid/ready FP32 element stream with a last flag. Downstream: one valid/ready FP32 sum per vector.
// - Drives the adder operands (add_a = running sum, add_b = input element) and registers the adder result every accepted beat.
// - The adder sits outside this block; this block sits directly upstream and downstream of it.
// PARAMETERS
// - CNT_W    16  width of the element counter and out_count
// - MAX_LEN  0   forced vector termination after MAX_LEN elements; 0 = unlimited
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      input element valid
// - in_ready   out  1      input element accepted when in_valid && in_ready
// - in_data    in   32     FP32 element
// - in_last    in   1      element is the last of its vector
// - add_a      out  32     adder operand A = running sum (acc)
// - add_b      out  32     adder operand B = in_data (direct, combinational)
// - add_sum    in   32     combinational adder result for add_a + add_b
// - out_valid  out  1      result valid
// - out_ready  in   1      result consumed when out_valid && out_ready
// - out_data   out  32     FP32 vector sum (registered)
// - out_count  out  CNT_W  elements summed in the vector; saturates at 2^CNT_W-1
// - out_forced out  1      vector was closed by MAX_LEN, not by in_last
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=ACC, acc=32'h0, count=0. out_valid=0, out_data=0, out_count=0, out_forced=0.
// - While rst=1, in_ready=0.
// - FSM ACC (collecting):
//   - in_ready = 1, add_a = acc.
//   - On accept: acc <= add_sum, count <= count+1 (saturating).
//   - The first element of a vector adds to acc=+0.0 (32'h00000000).
// - ACC -> OUT on an accepted beat with in_last=1, or with count+1 == MAX_LEN (MAX_LEN != 0).
//   - On that edge: out_data <= add_sum, out_count <= count+1 (saturating), out_forced <= !in_last, out_valid <= 1.
// - FSM OUT (holding):
//   - in_ready = 0; out_data, out_count and out_forced are held stable until the handshake.
//   - On out_valid && out_ready: out_valid <= 0, acc <= 0, count <= 0, state <= ACC.
//   - in_ready rises the cycle after the handshake, so there is no same-cycle restart.
// - Latency: result is valid 1 cycle after the last element is accepted. Throughput: 1 element/cycle in ACC.
// - Vector boundaries: an element arriving while in OUT is stalled, never dropped.
// - No element is ever merged across vector boundaries.
// - Counter: count saturates at 2^CNT_W-1 and never wraps. Summation continues after saturation.
// - Reset mid-vector or mid-OUT: the partial sum is discarded, there is no output, and the FSM returns to ACC.
// - Arithmetic: exactness is delegated to the adder. This block does no rounding and never alters add_sum, except as described under CONFIGURATION.
// CONFIGURATION
// - Macro FP32_ACC_NAN_STICKY_EN.
// - Defined: a sticky flag nan_seen is set by any accepted in_data with exponent 8'hFF and mantissa != 0.
//   - While nan_seen is set, acc and out_data are forced to 32'h7FC00000.
//   - nan_seen is cleared on rst and on the output handshake.
// - Undefined: no flag exists, and NaN propagation is whatever the adder produces.
// TESTING
// - 3F800000, 40000000, 40400000 (last on the 3rd) -> out_data=40C00000 (6.0), out_count=3, out_forced=0, 1 cycle after the 3rd accept.
// - Single beat C0A00000 with last=1 -> out_data=C0A00000, out_count=1.
// - 3FC00000 then BFC00000 (last) -> out_data=00000000, out_count=2.
// - Backpressure: hold out_ready=0 for 5 cycles after the result -> out_data stable, in_ready=0 throughout, a pending input stays unaccepted.
//   - Then out_ready=1 -> in_ready=1 on the next cycle.
// - MAX_LEN=4: stream five 3F800000 beats with no last -> first result 40800000, count=4, forced=1.
//   - The 5th beat then starts a new vector.
// - rst after 2 of 3 elements -> no out_valid; a following vector 40000000 (last) -> out_data=40000000, out_count=1.
// - With FP32_ACC_NAN_STICKY_EN defined: 3F800000, 7FC00001, 3F800000 (last) -> out_data=7FC00000.

Source files
------------

// File: rtl/fp32_stream_accumulator.sv
// -----------------------------------------------------------------------------
// fp32_stream_accumulator
//
// Purpose:
//   Streaming FP32 sum-reduction controller. It closes a feedback loop around
//   an external combinational FP32 adder. Each accepted element is added to
//   the running sum. One sum is produced per vector. A vector ends on in_last,
//   or after MAX_LEN elements when MAX_LEN is non-zero.
//
// Parameters:
//   CNT_W    width of the element counter and out_count (saturating)
//   MAX_LEN  forced vector termination length; 0 = unlimited
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        element stream handshake
//   in_data, in_last         FP32 element, last-of-vector flag
//   add_a, add_b             adder operands (running sum, current element)
//   add_sum                  adder result for add_a + add_b
//   out_valid/out_ready      result handshake
//   out_data                 registered FP32 vector sum
//   out_count                elements in the vector (saturating)
//   out_forced               vector closed by MAX_LEN rather than in_last
//
// Optional feature (macro FP32_ACC_NAN_STICKY_EN):
//   When the macro is defined, a sticky nan_seen flag is set by any accepted
//   quiet or signalling NaN. While the flag is set, the sum is forced to the
//   canonical quiet NaN 32'h7FC00000.
// -----------------------------------------------------------------------------
module fp32_stream_accumulator #(
    parameter int CNT_W   = 16,
    parameter int MAX_LEN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_forced
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [CNT_W:0] MAX_LEN_W = (CNT_W+1)'(MAX_LEN);
    localparam logic [CNT_W:0] ONE_W     = {{CNT_W{1'b0}}, 1'b1};

    state_t           r_state;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_forced;

    logic             w_accept;
    logic             w_out_hs;
    logic [CNT_W:0]   w_count_p1;
    logic [CNT_W-1:0] w_count_sat;
    logic             w_len_hit;
    logic [31:0]      w_sum;

    // in_ready is held low during reset. It is low in OUT, so an element that
    // arrives between vectors waits instead of being merged or dropped.
    assign in_ready = !rst && (r_state == ST_ACC);
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    assign add_a = r_acc;
    assign add_b = in_data;

    // The extra top bit keeps the MAX_LEN compare exact at the counter limit.
    assign w_count_p1  = {1'b0, r_count} + ONE_W;
    assign w_count_sat = (&r_count) ? r_count : w_count_p1[CNT_W-1:0];
    assign w_len_hit   = (MAX_LEN != 0) && (w_count_p1 == MAX_LEN_W);

`ifdef FP32_ACC_NAN_STICKY_EN
    logic r_nan_seen;
    logic w_nan_in;

    assign w_nan_in = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    // The current NaN beat forces its own sum, not only the beats after it.
    assign w_sum    = (r_nan_seen || w_nan_in) ? 32'h7FC0_0000 : add_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nan_seen <= 1'b0;
        end else if (w_accept && w_nan_in) begin
            r_nan_seen <= 1'b1;
        end else if (w_out_hs) begin
            r_nan_seen <= 1'b0;
        end
    end
`else
    assign w_sum = add_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACC;
            r_acc        <= 32'h0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'h0;
            r_out_count  <= '0;
            r_out_forced <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_count <= w_count_sat;
                        if (in_last || w_len_hit) begin
                            r_out_data   <= w_sum;
                            r_out_count  <= w_count_sat;
                            r_out_forced <= !in_last;
                            r_out_valid  <= 1'b1;
                            r_state      <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    // Restart from +0.0 so that the next vector begins clean.
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= 32'h0;
                        r_count     <= '0;
                        r_state     <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_count  = r_out_count;
    assign out_forced = r_out_forced;

endmodule
